alu_seq_checker: RTL

ALU_SEQ_CHECKER -- requirements
Module: alu_seq_checker

---
 rtl/alu_seq_checker.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_seq_checker.sv
// Sequenced exhaustive self-test of a 4-bit ALU: drives every (op, a, b) vector,
// waits SETTLE_CYC cycles, compares against a reference. Define ALU_CHK_FLAGS_EN to also check z/n/o/c.
module alu_seq_checker #(
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] op,
  input  logic [4:0] alu_out,
  input  logic       z,
  input  logic       n,
  input  logic       o,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [2:0] fail_op,
  output logic [3:0] fail_a,
  output logic [3:0] fail_b,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       last_vec;
  logic [4:0] exp_out;
  logic       exp_o;
  logic       mismatch;

  assign accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  assign last_vec = (op == 3'b111) && (a == 4'hf) && (b == 4'hf);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_DRIVE;
      S_DRIVE:        state_d = S_SETTLE;
      S_SETTLE:       if (settle_cnt == 4'(SETTLE_CYC - 1)) state_d = S_CHECK;
      S_CHECK:        state_d = last_vec ? S_DONE : S_DRIVE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      settle_cnt <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DRIVE)       settle_cnt <= 4'd0;
      else if (state_q == S_SETTLE) settle_cnt <= settle_cnt + 4'd1;
    end
  end

  // Reference ALU; op 011 computes B-A so out[4] is the borrow.
  always_comb begin
    exp_out = 5'd0;
    exp_o   = 1'b0;
    case (op)
      3'b000: exp_out = {1'b0, a};
      3'b001: begin
        exp_out = {1'b0, a} + {1'b0, b};
        exp_o   = (a[3] == b[3]) && (exp_out[3] != a[3]);
      end
      3'b011: begin
        exp_out = {1'b0, b} - {1'b0, a};
        exp_o   = (a[3] != b[3]) && (exp_out[3] != b[3]);
      end
      3'b100:  exp_out = {1'b0, ~a};
      3'b101:  exp_out = {1'b0, a & b};
      3'b110:  exp_out = {1'b0, a | b};
      3'b111:  exp_out = {1'b0, a ^ b};
      default: exp_out = 5'd0;
    endcase
  end

`ifdef ALU_CHK_FLAGS_EN
  assign mismatch = (alu_out != exp_out) ||
                    (z != (exp_out[3:0] == 4'd0)) ||
                    (n != exp_out[3]) ||
                    (c != exp_out[4]) ||
                    (o != exp_o);
`else
  logic unused_flags;
  assign unused_flags = ^{z, n, o, c, exp_o};
  assign mismatch     = (alu_out != exp_out);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= 4'd0;
      b         <= 4'd0;
      op        <= 3'd0;
      err_count <= 8'd0;
      fail_op   <= 3'd0;
      fail_a    <= 4'd0;
      fail_b    <= 4'd0;
    end else if (accept) begin
      a         <= 4'd0;
      b         <= 4'd0;
      op        <= 3'd0;
      err_count <= 8'd0;
      fail_op   <= 3'd0;
      fail_a    <= 4'd0;
      fail_b    <= 4'd0;
    end else if (state_q == S_CHECK) begin
      if (mismatch) begin
        if (err_count != 8'hff) err_count <= err_count + 8'd1;
        // err_count never returns to zero mid-sweep, so zero marks the first miss.
        if (err_count == 8'd0) begin
          fail_op <= op;
          fail_a  <= a;
          fail_b  <= b;
        end
      end
      if (!last_vec) begin
        b <= b + 4'd1;
        if (b == 4'hf) begin
          a <= a + 4'd1;
          if (a == 4'hf) op <= (op == 3'b001) ? 3'b011 : op + 3'd1;
        end
      end
    end
  end

  assign busy      = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_count == 8'd0);
  assign dbg_state = state_q;

endmodule
